// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//
// Purpose:
//   Small FIFO sitting between the instruction-fetch / I-cache response path
//   and the decode (ID) stage. Each entry carries {pc, instruction,
//   fetch-address-error}. The head entry is presented to decode as
//   validD/pcD/instrD/adelD. A pipeline flush (mispredict, exception, eret)
//   discards every buffered entry.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 2)
//   PTR_W  pointer width, log2(DEPTH)
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous reset, active low
//   flush        drop all entries; wins over push and pop
//   stallD       decode stalled, head entry is held
//   in_valid     fetch side presents an entry
//   in_pc        PC of the fetched instruction
//   in_instr     fetched instruction word
//   in_adel      fetch address error for this entry
//   in_ready     queue can accept an entry this cycle
//   almost_full  occupancy >= DEPTH-1 (fetch throttle hint)
//   validD       head entry valid
//   pcD          head PC (0 when empty)
//   instrD       head instruction (0 = NOP when empty)
//   adelD        head fetch address error (0 when empty)
//   count        current occupancy, 0..DEPTH
//
// Build option:
//   IFQ_BYPASS_EN  when defined, an entry arriving at an empty, unstalled,
//                  unflushed queue is forwarded straight to the head outputs
//                  in the same cycle and is not stored.
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stallD,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  input  logic             in_adel,
  output logic             in_ready,
  output logic             almost_full,
  output logic             validD,
  output logic [31:0]      pcD,
  output logic [31:0]      instrD,
  output logic             adelD,
  output logic [PTR_W:0]   count
);

  // Occupancy thresholds expressed in the counter's own width.
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] AF_CNT   = (PTR_W+1)'(DEPTH - 1);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     cnt_q,    cnt_d;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic   q_empty;
  logic   q_full;
  logic   q_valid;
  logic   bypass;
  logic   push;
  logic   pop;
  entry_t in_entry;
  entry_t head_entry;

  assign q_empty = (cnt_q == '0);
  assign q_full  = (cnt_q == FULL_CNT);
  assign q_valid = ~q_empty;

`ifdef IFQ_BYPASS_EN
  // Empty queue, decode ready, no flush: hand the entry straight to decode.
  // A stalled decode falls back to the normal write path.
  assign bypass = q_empty & in_valid & ~flush & ~stallD;
`else
  assign bypass = 1'b0;
`endif

  // in_ready is derived from the registered count only, so stallD never
  // reaches in_ready combinationally.
  assign in_ready    = ~q_full;
  assign almost_full = (cnt_q >= AF_CNT);

  // A bypassed entry is consumed in flight: it is neither stored nor popped.
  assign push = in_valid & in_ready & ~flush & ~bypass;
  assign pop  = q_valid & ~stallD & ~flush;

  assign in_entry = '{pc: in_pc, instr: in_instr, adel: in_adel};

  // ---------------------------------------------------------------------------
  // Next-state logic for pointers and occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;  // idle, or push+pop cancel out
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array: one enable per slot, no reset (contents are qualified by
  // cnt_q, so stale data is never observed).
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic slot_we;
      assign slot_we = push & (wr_ptr_q == PTR_W'(gi));

      always_ff @(posedge clk) begin
        if (slot_we) begin
          mem_q[gi] <= in_entry;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Head presentation
  // ---------------------------------------------------------------------------
  always_comb begin
    head_entry = '0;
    if (q_valid) begin
      head_entry = mem_q[rd_ptr_q];
    end else if (bypass) begin
      head_entry = in_entry;
    end
  end

  // An empty head is forced to all-zero; instrD = 0 decodes as sll $0,$0,0.
  assign validD = q_valid | bypass;
  assign pcD    = head_entry.pc;
  assign instrD = head_entry.instr;
  assign adelD  = head_entry.adel;
  assign count  = cnt_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        stallD;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_adel;
  logic        in_ready;
  logic        almost_full;
  logic        validD;
  logic [31:0] pcD;
  logic [31:0] instrD;
  logic        adelD;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  inst_fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .stallD      (stallD),
    .in_valid    (in_valid),
    .in_pc       (in_pc),
    .in_instr    (in_instr),
    .in_adel     (in_adel),
    .in_ready    (in_ready),
    .almost_full (almost_full),
    .validD      (validD),
    .pcD         (pcD),
    .instrD      (instrD),
    .adelD       (adelD),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word derived from the PC so instrD is checked independently.
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h2408_5A5A;
  endfunction

  typedef struct packed {
    logic        f;
    logic        s;
    logic        v;
    logic [31:0] pc;
    logic        a;
    logic        e_rdy;
    logic        e_af;
    logic        e_v;
    logic [31:0] e_pc;
    logic        e_adel;
    logic [2:0]  e_cnt;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic drive(input logic f, input logic s, input logic v,
                       input logic [31:0] pc, input logic a);
    flush    = f;
    stallD   = s;
    in_valid = v;
    in_pc    = pc;
    in_instr = instr_of(pc);
    in_adel  = a;
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  initial begin
    // Expected columns describe the state visible before the clock edge that
    // applies the row's inputs.
    //          f  s  v  pc            a  rdy af v  pcD           adel cnt
    vecs[0]  = '{0, 0, 0, 32'h0,        0, 1, 0, 0, 32'h0,        0, 3'd0}; // idle after reset
    vecs[1]  = '{0, 1, 1, 32'hBFC00000, 0, 1, 0, 0, 32'h0,        0, 3'd0};
    vecs[2]  = '{0, 1, 1, 32'hBFC00004, 0, 1, 0, 1, 32'hBFC00000, 0, 3'd1};
    vecs[3]  = '{0, 1, 1, 32'hBFC00008, 0, 1, 0, 1, 32'hBFC00000, 0, 3'd2};
    vecs[4]  = '{0, 1, 1, 32'hBFC0000C, 0, 1, 1, 1, 32'hBFC00000, 0, 3'd3};
    vecs[5]  = '{0, 1, 1, 32'hBFC00010, 0, 0, 1, 1, 32'hBFC00000, 0, 3'd4}; // full: dropped
    vecs[6]  = '{0, 0, 0, 32'h0,        0, 0, 1, 1, 32'hBFC00000, 0, 3'd4};
    vecs[7]  = '{0, 0, 0, 32'h0,        0, 1, 1, 1, 32'hBFC00004, 0, 3'd3};
    vecs[8]  = '{0, 0, 0, 32'h0,        0, 1, 0, 1, 32'hBFC00008, 0, 3'd2};
    vecs[9]  = '{0, 0, 0, 32'h0,        0, 1, 0, 1, 32'hBFC0000C, 0, 3'd1};
    vecs[10] = '{0, 0, 0, 32'h0,        0, 1, 0, 0, 32'h0,        0, 3'd0}; // 0x...10 never seen
    vecs[11] = '{0, 0, 1, 32'hBFC00002, 1, 1, 0, 0, 32'h0,        0, 3'd0}; // misaligned fetch
    vecs[12] = '{0, 1, 1, 32'hBFC00014, 0, 1, 0, 1, 32'hBFC00002, 1, 3'd1};
    vecs[13] = '{0, 0, 0, 32'h0,        0, 1, 0, 1, 32'hBFC00002, 1, 3'd2};
    vecs[14] = '{0, 0, 0, 32'h0,        0, 1, 0, 1, 32'hBFC00014, 0, 3'd1};
    vecs[15] = '{0, 1, 1, 32'h80000000, 0, 1, 0, 0, 32'h0,        0, 3'd0};
    vecs[16] = '{0, 1, 1, 32'h80000004, 0, 1, 0, 1, 32'h80000000, 0, 3'd1};
    vecs[17] = '{0, 1, 1, 32'h80000008, 0, 1, 0, 1, 32'h80000000, 0, 3'd2};
    vecs[18] = '{1, 1, 1, 32'h80000100, 0, 1, 1, 1, 32'h80000000, 0, 3'd3}; // flush beats push
    vecs[19] = '{0, 1, 0, 32'h0,        0, 1, 0, 0, 32'h0,        0, 3'd0};
    vecs[20] = '{0, 0, 0, 32'h0,        0, 1, 0, 0, 32'h0,        0, 3'd0};

    rst = 1'b0;
    drive(0, 0, 0, 32'h0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      logic [31:0] e_instr;
      @(negedge clk);
      drive(vecs[i].f, vecs[i].s, vecs[i].v, vecs[i].pc, vecs[i].a);
      #2;
      e_instr = vecs[i].e_v ? instr_of(vecs[i].e_pc) : 32'h0;
      check($sformatf("vec%0d", i),
            {57'h0, in_ready, almost_full, validD, pcD, instrD, adelD, count},
            {57'h0, vecs[i].e_rdy, vecs[i].e_af, vecs[i].e_v, vecs[i].e_pc,
             e_instr, vecs[i].e_adel, vecs[i].e_cnt});
    end

    // Simultaneous push/pop at count 2 across pointer wrap.
    @(negedge clk);
    drive(0, 1, 1, 32'h00400000, 0);
    @(negedge clk);
    drive(0, 1, 1, 32'h00400004, 0);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 1, 32'h00400000 + 32'(4 * (k + 2)), 0);
      #2;
      check($sformatf("pp%0d_cnt", k), {125'h0, count}, {125'h0, 3'd2});
      check($sformatf("pp%0d_pc", k), {96'h0, pcD}, {96'h0, 32'h00400000 + 32'(4 * k)});
      check($sformatf("pp%0d_rdy", k), {127'h0, in_ready}, {127'h0, 1'b1});
      @(negedge clk);
    end
    drive(0, 0, 0, 32'h0, 0);
    #2;
    check("pp_drain0", {96'h0, pcD}, {96'h0, 32'h00400028});
    @(negedge clk);
    #2;
    check("pp_drain1", {96'h0, pcD}, {96'h0, 32'h0040002C});
    @(negedge clk);
    #2;
    check("pp_empty", {124'h0, validD, count}, {124'h0, 1'b0, 3'd0});

    // Asynchronous reset between clock edges.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(0, 1, 1, 32'h90000000 + 32'(4 * k), 0);
    end
    @(negedge clk);
    drive(0, 1, 0, 32'h0, 0);
    #2;
    check("ar_pre_cnt", {125'h0, count}, {125'h0, 3'd3});
    #1 rst = 1'b0;
    #1;
    check("ar_async", {124'h0, validD, count}, {124'h0, 1'b0, 3'd0});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1, 1, 32'h12345678, 0);
    @(negedge clk);
    drive(0, 1, 0, 32'h0, 0);
    #2;
    check("ar_head", {92'h0, validD, pcD, count}, {92'h0, 1'b1, 32'h12345678, 3'd1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
